// File: rtl/local_inject_queue_pkg.sv
// Shared definitions for the local injection path: channel count, default flit width
// and the lowest-set-bit priority select reused by the eject/inject grant logic.
package local_inject_queue_pkg;

    localparam int NUM_CHANNEL    = 5;
    localparam int FLIT_W_DEFAULT = 64;

    typedef logic [NUM_CHANNEL-1:0] chanVec_t;

    // Isolates the lowest set bit (two's-complement trick); zero in gives zero out.
    function automatic chanVec_t lowestSetBit(input chanVec_t v);
        return v & (~v + chanVec_t'(1));
    endfunction

endpackage

// File: rtl/local_inject_queue_fifo.sv
// Generic count-based circular FIFO: power-of-two depth, pointers wrap naturally,
// separate occupancy count so full and empty are unambiguous.
module sync_fifo_cnt #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign count_o = count_q;
    // Head is forced to zero when empty so the output is clean out of reset.
    assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

endmodule

// File: rtl/local_inject_queue.sv
// Local PE injection queue: buffers PE flits and drives the head onto the lowest granted
// channel. Optional starvation alarm enabled by defining INJECT_STARVE_ALARM_EN.
module local_inject_queue
    import local_inject_queue_pkg::*;
#(
    parameter int FLIT_W        = FLIT_W_DEFAULT,
    parameter int DEPTH         = 4,
    parameter int CNT_W         = $clog2(DEPTH) + 1,
    parameter int STARVE_THRESH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   peValid,
    input  logic [FLIT_W-1:0]      peFlit,
    output logic                   peReady,
    input  logic [NUM_CHANNEL-1:0] localInjectGrant,
    output logic                   injectReq,
    output logic [FLIT_W-1:0]      injectFlit,
    output logic [NUM_CHANNEL-1:0] injectSel,
`ifdef INJECT_STARVE_ALARM_EN
    output logic                   starveAlarm,
`endif
    output logic [CNT_W-1:0]       occupancy,
    output logic                   grantErr
);

    logic     fifoFull, fifoEmpty;
    logic     pop;
    logic     multiHot;
    logic     grantErr_q, grantErr_d;
    chanVec_t grantLow;

    sync_fifo_cnt #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) uFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (peValid),
        .wdata_i (peFlit),
        .pop_i   (pop),
        .rdata_o (injectFlit),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (occupancy)
    );

    // peReady depends only on registered count, never on the grant.
    assign peReady   = !fifoFull;
    assign injectReq = !fifoEmpty;
    assign grantLow  = lowestSetBit(localInjectGrant);
    assign injectSel = injectReq ? grantLow : '0;
    assign pop       = injectReq && (|localInjectGrant);
    assign multiHot  = |(localInjectGrant & (localInjectGrant - chanVec_t'(1)));

    assign grantErr_d = grantErr_q || (injectReq && multiHot);
    assign grantErr   = grantErr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grantErr_q <= 1'b0;
        else        grantErr_q <= grantErr_d;
    end

`ifdef INJECT_STARVE_ALARM_EN
    localparam int SC_W = $clog2(STARVE_THRESH + 1);

    logic [SC_W-1:0] starveCnt_q, starveCnt_d;

    // Counts consecutive waiting cycles; saturates at the threshold.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!injectReq || pop)
            starveCnt_d = '0;
        else if (starveCnt_q < SC_W'(STARVE_THRESH))
            starveCnt_d = starveCnt_q + SC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starveCnt_q <= '0;
        else        starveCnt_q <= starveCnt_d;
    end

    assign starveAlarm = (starveCnt_q >= SC_W'(STARVE_THRESH));
`endif

endmodule
